adivinhador_binario: RTL and testbench
======================================

// Module: adivinhador_binario
// PURPOSE
//  Automatic player for the bomb game. Drives guesses into the less/greater hint logic and reads its hint back.
//  Binary-searches secret A (LARG_A bits), confirms it, then binary-searches and confirms secret B (LARG_B bits).
//  Used for demo/attract mode and as a self-check of the hint path on the board.
// PARAMETERS
//  LARG_A    4  width of secret A / guess bus
//  LARG_B    3  width of secret B (zero-extended onto TENTATIVA)
//  LAT_DICA  2  cycles from the ENTER pulse to a valid hint/ACERTOU sample (>=1)
// PORTS
//  CLOCK            in   1       single clock, all logic on posedge
//  RESET_N          in   1       synchronous, active-low reset
//  START            in   1       level; sampled in IDLE only; starts a run
//  ABORT            in   1       level; returns to IDLE from any state
//  MENOR_OU_MAIOR   in   1       hint: 1 = last guess > secret, 0 = guess <= secret
//  ACERTOU_SENHA_A  in   1       secret A already confirmed
//  ACERTOU_SENHA_B  in   1       secret B confirmed
//  TENTATIVA        out  LARG_A  current guess; held stable across the ENTER pulse
//  ENTER            out  1       one-cycle strobe submitting TENTATIVA
//  OCUPADO          out  1       high in every state except IDLE/PRONTO/ERRO
//  PRONTO           out  1       both secrets confirmed (sticky until START/ABORT)
//  ERRO             out  1       confirm failed (sticky until START/ABORT)
//  NUM_TENT         out  4       ENTER strobes issued this run (saturates at 15)
// BEHAVIOUR
//  Reset (RESET_N=0 at posedge): state IDLE; all outputs 0; lo=hi=0; fase=A.
//  Search registers: lo, hi (LARG_A bits); fase in {A,B}.
//    Phase A starts with lo=0, hi=2^LARG_A-1. Phase B starts with lo=0, hi=2^LARG_B-1.
//  mid = (lo+hi+1)>>1, computed LARG_A+1 bits wide with no overflow; mid>lo whenever lo<hi.
//  FSM:
//   IDLE     START=1 -> CALC. Clears PRONTO/ERRO/NUM_TENT; loads phase-A bounds.
//   CALC     lo<hi -> TENTATIVA<=mid, next ENVIA. lo==hi -> TENTATIVA<=lo, next CONF_ENV.
//   ENVIA    ENTER=1 for exactly this cycle; NUM_TENT++ -> ESPERA.
//   ESPERA   count LAT_DICA cycles after the ENTER cycle, then sample the hint.
//            hint=1 -> hi<=TENTATIVA-1; hint=0 -> lo<=TENTATIVA. Next CALC.
//   CONF_ENV ENTER=1 for one cycle; NUM_TENT++ -> CONF_ESP.
//   CONF_ESP wait LAT_DICA cycles, then sample the confirm flag:
//            phase A: ACERTOU_SENHA_A=1 -> fase<=B, load phase-B bounds, next CALC; else -> ERRO.
//            phase B: ACERTOU_SENHA_B=1 -> PRONTO; else -> ERRO.
//   PRONTO / ERRO  terminal; flag high; START=1 -> IDLE-start sequence (same as IDLE+START).
//  TENTATIVA changes only in CALC; it never changes during ENVIA/ESPERA/CONF_*.
//  ENTER is never high on two consecutive cycles. Minimum gap between strobes = LAT_DICA+2 cycles.
//  ABORT has priority over every transition, START included. It gives IDLE, ENTER=0, OCUPADO=0, PRONTO=ERRO=0.
//    TENTATIVA and NUM_TENT hold their values.
//  START while OCUPADO is ignored. Reset mid-run behaves as ABORT and also zeroes TENTATIVA/NUM_TENT.
//  The hint input is sampled only in ESPERA; the ACERTOU inputs only in CONF_ESP. All other values are don't-care.
//  Strobe count per run: LARG_A + 1 + LARG_B + 1 (9 with defaults).
// STRUCTURE
//  Shared package (bomba_pkg): state enum estado_adiv_t; LARG_A/LARG_B defaults; hint encoding constants.
//  One sub-module: espera_latencia. A loadable down-counter that raises FIM after LAT_DICA cycles.
//    It is reused for ESPERA and CONF_ESP.
//  The search datapath (lo/hi/mid) stays inline.
// TESTING (bench models the hint block: registers compare on ENTER, result valid after LAT_DICA)
//  A=9, B=5 -> TENTATIVA strobes 8,12,10,9,9(conf),4,6,5,5(conf); PRONTO=1; NUM_TENT=9.
//  A=0, B=7 -> strobes 8,4,2,1,0,4,6,7,7; PRONTO=1. A=15 -> 8,12,14,15,15 (upper boundary).
//  Bench holds ACERTOU_SENHA_A=0 at the first confirm -> ERRO=1 and OCUPADO=0. A later START clears ERRO and restarts with guess 8.
//  ABORT asserted during ESPERA of the 3rd strobe -> IDLE next cycle. No further ENTER; flags cleared.
//  START held high through a run -> no re-entry while OCUPADO. Check ENTER is 1-cycle with the gap >= LAT_DICA+2.
//  RESET_N=0 during CONF_ESP -> all outputs 0 at the next posedge; a clean run afterwards passes.

Source files
------------

// File: rtl/bomba_pkg.sv
// Shared definitions for the bomb game: the automatic player's state encoding,
// default widths/latency and the encoding of the less/greater hint.
package bomba_pkg;

  localparam int LARG_A_PAD   = 4;
  localparam int LARG_B_PAD   = 3;
  localparam int LAT_DICA_PAD = 2;

  localparam logic DICA_MAIOR       = 1'b1;  // last guess is above the secret
  localparam logic DICA_MENOR_IGUAL = 1'b0;  // last guess is at or below the secret

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CALC     = 3'd1,
    ST_ENVIA    = 3'd2,
    ST_ESPERA   = 3'd3,
    ST_CONF_ENV = 3'd4,
    ST_CONF_ESP = 3'd5,
    ST_PRONTO   = 3'd6,
    ST_ERRO     = 3'd7
  } estado_adiv_t;

  typedef enum logic {
    FASE_A = 1'b0,
    FASE_B = 1'b1
  } fase_t;

  function automatic logic estado_ocupado(input estado_adiv_t estado);
    logic ocupado;
    case (estado)
      ST_IDLE, ST_PRONTO, ST_ERRO: ocupado = 1'b0;
      default:                     ocupado = 1'b1;
    endcase
    return ocupado;
  endfunction

endpackage

// File: rtl/adivinhador_binario_espera_latencia.sv
// Loadable down-counter: after a load, fim is high on the LAT_DICA-th cycle,
// which is the cycle on which the hint/confirm inputs may be sampled.
module espera_latencia #(
  parameter int LAT_DICA = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic carrega,
  output logic fim
);

  localparam int LARG_CNT = $clog2(LAT_DICA + 1);
  localparam logic [LARG_CNT-1:0] CNT_CARGA = LARG_CNT'(LAT_DICA);
  localparam logic [LARG_CNT-1:0] CNT_UM    = LARG_CNT'(1);
  localparam logic [LARG_CNT-1:0] CNT_ZERO  = LARG_CNT'(0);

  logic [LARG_CNT-1:0] cnt_r;

  // Down-counter, reloaded on every strobe and parked at zero when expired.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (carrega) begin
      cnt_r <= CNT_CARGA;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_UM;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign fim = (cnt_r == CNT_UM);

endmodule

// File: rtl/adivinhador_binario.sv
// Automatic bomb-game player: binary-searches secret A then secret B through the
// external hint logic, confirming each with a final strobe of the converged value.
module adivinhador_binario
  import bomba_pkg::*;
#(
  parameter int LARG_A   = LARG_A_PAD,
  parameter int LARG_B   = LARG_B_PAD,
  parameter int LAT_DICA = LAT_DICA_PAD
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic              MENOR_OU_MAIOR,
  input  logic              ACERTOU_SENHA_A,
  input  logic              ACERTOU_SENHA_B,
  output logic [LARG_A-1:0] TENTATIVA,
  output logic              ENTER,
  output logic              OCUPADO,
  output logic              PRONTO,
  output logic              ERRO,
  output logic [3:0]        NUM_TENT
);

  localparam logic [LARG_A-1:0] ZERO_A  = {LARG_A{1'b0}};
  localparam logic [LARG_A-1:0] UM_A    = {{(LARG_A-1){1'b0}}, 1'b1};
  localparam logic [LARG_A-1:0] HI_A    = {LARG_A{1'b1}};
  localparam logic [LARG_A-1:0] HI_B    = LARG_A'((32'd1 << LARG_B) - 32'd1);
  localparam logic [LARG_A:0]   UM_SOMA = {{LARG_A{1'b0}}, 1'b1};

  estado_adiv_t      estado_r, estado_s;
  fase_t             fase_r, fase_s;
  logic [LARG_A-1:0] lo_r, lo_s, hi_r, hi_s, tent_r, tent_s;
  logic [3:0]        num_r, num_s, num_inc_s;
  logic [LARG_A:0]   soma_s;
  logic [LARG_A-1:0] mid_s;
  logic              enter_r, ocupado_r, pronto_r, erro_r;
  logic              carrega_s, fim_s;

  // One extra bit keeps lo+hi+1 exact; the upper-rounded midpoint guarantees progress.
  assign soma_s    = {1'b0, lo_r} + {1'b0, hi_r} + UM_SOMA;
  assign mid_s     = soma_s[LARG_A:1];
  assign num_inc_s = (num_r == 4'd15) ? num_r : (num_r + 4'd1);
  assign carrega_s = (estado_r == ST_ENVIA) || (estado_r == ST_CONF_ENV);

  espera_latencia #(.LAT_DICA(LAT_DICA)) u_espera (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .carrega (carrega_s),
    .fim     (fim_s)
  );

  // Next state and next search/datapath values.
  always_comb begin
    estado_s = estado_r;
    fase_s   = fase_r;
    lo_s     = lo_r;
    hi_s     = hi_r;
    tent_s   = tent_r;
    num_s    = num_r;
    if (ABORT) begin
      estado_s = ST_IDLE;
    end else begin
      case (estado_r)
        ST_IDLE, ST_PRONTO, ST_ERRO: begin
          if (START) begin
            estado_s = ST_CALC;
            fase_s   = FASE_A;
            lo_s     = ZERO_A;
            hi_s     = HI_A;
            num_s    = 4'd0;
          end else begin
            estado_s = estado_r;
          end
        end
        ST_CALC: begin
          if (lo_r < hi_r) begin
            tent_s   = mid_s;
            estado_s = ST_ENVIA;
          end else begin
            tent_s   = lo_r;
            estado_s = ST_CONF_ENV;
          end
        end
        ST_ENVIA: begin
          num_s    = num_inc_s;
          estado_s = ST_ESPERA;
        end
        ST_ESPERA: begin
          if (fim_s) begin
            if (MENOR_OU_MAIOR == DICA_MAIOR) begin
              hi_s = tent_r - UM_A;
            end else begin
              lo_s = tent_r;
            end
            estado_s = ST_CALC;
          end else begin
            estado_s = ST_ESPERA;
          end
        end
        ST_CONF_ENV: begin
          num_s    = num_inc_s;
          estado_s = ST_CONF_ESP;
        end
        ST_CONF_ESP: begin
          if (!fim_s) begin
            estado_s = ST_CONF_ESP;
          end else if (fase_r == FASE_A) begin
            if (ACERTOU_SENHA_A) begin
              fase_s   = FASE_B;
              lo_s     = ZERO_A;
              hi_s     = HI_B;
              estado_s = ST_CALC;
            end else begin
              estado_s = ST_ERRO;
            end
          end else begin
            estado_s = ACERTOU_SENHA_B ? ST_PRONTO : ST_ERRO;
          end
        end
        default: begin
          estado_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and outputs; outputs are registered from the next state.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      estado_r  <= ST_IDLE;
      fase_r    <= FASE_A;
      lo_r      <= ZERO_A;
      hi_r      <= ZERO_A;
      tent_r    <= ZERO_A;
      num_r     <= 4'd0;
      enter_r   <= 1'b0;
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
      erro_r    <= 1'b0;
    end else begin
      estado_r  <= estado_s;
      fase_r    <= fase_s;
      lo_r      <= lo_s;
      hi_r      <= hi_s;
      tent_r    <= tent_s;
      num_r     <= num_s;
      enter_r   <= (estado_s == ST_ENVIA) || (estado_s == ST_CONF_ENV);
      ocupado_r <= estado_ocupado(estado_s);
      pronto_r  <= (estado_s == ST_PRONTO);
      erro_r    <= (estado_s == ST_ERRO);
    end
  end

  assign TENTATIVA = tent_r;
  assign ENTER     = enter_r;
  assign OCUPADO   = ocupado_r;
  assign PRONTO    = pronto_r;
  assign ERRO      = erro_r;
  assign NUM_TENT  = num_r;

endmodule

// File: tb/tb_adivinhador_binario.sv
// Self-checking bench: models the hint block (compare on ENTER, valid LAT_DICA
// cycles later) and checks strobe sequences, flags, counts and corner cases.
module tb_adivinhador_binario;
  import bomba_pkg::*;

  localparam int LA   = 4;
  localparam int LB   = 3;
  localparam int LAT  = 2;
  localparam int NSTR = LA + 1 + LB + 1;

  logic          CLOCK = 1'b0;
  logic          RESET_N, START, ABORT;
  logic          MENOR_OU_MAIOR, ACERTOU_SENHA_A, ACERTOU_SENHA_B;
  logic [LA-1:0] TENTATIVA;
  logic          ENTER, OCUPADO, PRONTO, ERRO;
  logic [3:0]    NUM_TENT;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int a;
    int b;
    bit oka;
    int seq[NSTR];
    int nexp;
    bit pronto;
  } vec_t;

  vec_t tbl[5];

  // hint-block model state (written only by the monitor, except the run inputs)
  int sec_a, sec_b, run_id;
  bit ok_a;
  logic [2:0] pipe[0:LAT];
  int strobes[$];
  int enter_cyc[$];

  always #5 CLOCK = ~CLOCK;

  adivinhador_binario #(.LARG_A(LA), .LARG_B(LB), .LAT_DICA(LAT)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .MENOR_OU_MAIOR(MENOR_OU_MAIOR), .ACERTOU_SENHA_A(ACERTOU_SENHA_A),
    .ACERTOU_SENHA_B(ACERTOU_SENHA_B), .TENTATIVA(TENTATIVA), .ENTER(ENTER),
    .OCUPADO(OCUPADO), .PRONTO(PRONTO), .ERRO(ERRO), .NUM_TENT(NUM_TENT)
  );

  assign MENOR_OU_MAIOR  = pipe[LAT][2];
  assign ACERTOU_SENHA_A = pipe[LAT][1];
  assign ACERTOU_SENHA_B = pipe[LAT][0];

  // Hint block model and strobe recorder; pipe[k] holds the result k cycles after the strobe.
  always @(negedge CLOCK) begin
    int g, sec, seen_id, n_str, cyc;
    logic h, aa, ab;
    cyc++;
    if (seen_id != run_id) begin
      seen_id = run_id;
      n_str = 0;
      for (int k = 0; k <= LAT; k++) pipe[k] = 3'b000;
    end
    for (int k = LAT; k >= 1; k--) pipe[k] = pipe[k-1];
    if (ENTER === 1'b1) begin
      g = int'(TENTATIVA);
      n_str++;
      sec = (n_str <= LA + 1) ? sec_a : sec_b;
      h  = (g > sec);
      aa = pipe[0][1];
      ab = pipe[0][0];
      if (n_str == LA + 1) aa = (g == sec_a) && ok_a;
      if (n_str == NSTR) ab = (g == sec_b);
      pipe[0] = {h, aa, ab};
      strobes.push_back(g);
      enter_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_strobes(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (strobes.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLOCK);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (OCUPADO == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLOCK);
    end
  endtask

  task automatic start_run(input int a, input int b, input bit oka);
    sec_a = a;
    sec_b = b;
    ok_a  = oka;
    run_id++;
    @(negedge CLOCK);
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
  endtask

  // Reference: the spec's search rules with plain integers.
  function automatic void ref_run(input int a, input int b, output int seq[NSTR]);
    int lo, hi, g, k;
    k = 0;
    for (int ph = 0; ph < 2; ph++) begin
      lo = 0;
      hi = (ph == 0) ? (1 << LA) - 1 : (1 << LB) - 1;
      while (lo < hi) begin
        g = (lo + hi + 1) / 2;
        seq[k] = g;
        k++;
        if (g > ((ph == 0) ? a : b)) hi = g - 1;
        else lo = g;
      end
      seq[k] = lo;
      k++;
    end
  endfunction

  task automatic finish_check(input string tag, input int base, input int exp[NSTR],
                              input int nexp, input bit pr);
    bit ok;
    wait_idle(ok);
    check({tag, "_done"}, int'(ok), 1);
    check({tag, "_nstrobes"}, strobes.size() - base, nexp);
    for (int k = 0; k < nexp && base + k < strobes.size(); k++) begin
      check($sformatf("%s_strobe%0d", tag, k), strobes[base+k], exp[k]);
      if (k > 0) begin
        checks++;
        if (enter_cyc[base+k] - enter_cyc[base+k-1] < LAT + 2) begin
          failures++;
          $display("FAIL %s_gap%0d: got %0d cycles, need >= %0d", tag, k,
                   enter_cyc[base+k] - enter_cyc[base+k-1], LAT + 2);
        end
      end
    end
    check({tag, "_pronto"}, int'(PRONTO), int'(pr));
    check({tag, "_erro"}, int'(ERRO), int'(!pr));
    check({tag, "_num_tent"}, int'(NUM_TENT), nexp);
  endtask

  task automatic do_run(input string tag, input int a, input int b, input bit oka,
                        input int exp[NSTR], input int nexp, input bit pr);
    int base;
    base = strobes.size();
    start_run(a, b, oka);
    check({tag, "_busy_after_start"}, int'(OCUPADO), 1);
    check({tag, "_erro_cleared"}, int'(ERRO), 0);
    finish_check(tag, base, exp, nexp, pr);
  endtask

  initial begin
    int base, exp[NSTR];
    bit ok;
    RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0;
    run_id = 0; sec_a = 0; sec_b = 0; ok_a = 1'b1;

    tbl[0] = '{a: 9,  b: 5, oka: 1'b1, seq: '{8, 12, 10, 9, 9, 4, 6, 5, 5}, nexp: 9, pronto: 1'b1};
    tbl[1] = '{a: 0,  b: 7, oka: 1'b1, seq: '{8, 4, 2, 1, 0, 4, 6, 7, 7},   nexp: 9, pronto: 1'b1};
    tbl[2] = '{a: 15, b: 0, oka: 1'b1, seq: '{8, 12, 14, 15, 15, 4, 2, 1, 0}, nexp: 9, pronto: 1'b1};
    tbl[3] = '{a: 9,  b: 5, oka: 1'b0, seq: '{8, 12, 10, 9, 9, 0, 0, 0, 0}, nexp: 5, pronto: 1'b0};
    tbl[4] = '{a: 6,  b: 3, oka: 1'b1, seq: '{8, 4, 6, 7, 6, 4, 2, 3, 3},   nexp: 9, pronto: 1'b1};

    repeat (3) @(negedge CLOCK);
    check("rst_tentativa", int'(TENTATIVA), 0);
    check("rst_enter", int'(ENTER), 0);
    check("rst_ocupado", int'(OCUPADO), 0);
    check("rst_pronto", int'(PRONTO), 0);
    check("rst_erro", int'(ERRO), 0);
    check("rst_num_tent", int'(NUM_TENT), 0);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLOCK);
    check("idle_without_start", int'(OCUPADO), 0);

    for (int i = 0; i < 5; i++) begin
      do_run($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].oka,
             tbl[i].seq, tbl[i].nexp, tbl[i].pronto);
    end

    // ABORT in the wait after the third strobe
    base = strobes.size();
    start_run(9, 5, 1'b1);
    wait_strobes(base + 3, ok);
    check("abort_reach3", int'(ok), 1);
    @(negedge CLOCK);
    ABORT = 1'b1;
    @(negedge CLOCK);
    ABORT = 1'b0;
    check("abort_ocupado", int'(OCUPADO), 0);
    check("abort_enter", int'(ENTER), 0);
    check("abort_pronto", int'(PRONTO), 0);
    check("abort_erro", int'(ERRO), 0);
    check("abort_tent_hold", int'(TENTATIVA), 10);
    check("abort_num_hold", int'(NUM_TENT), 3);
    repeat (20) @(negedge CLOCK);
    check("abort_no_more_enter", strobes.size() - base, 3);

    // START held through the run must not restart it
    base = strobes.size();
    sec_a = 12; sec_b = 1; ok_a = 1'b1;
    run_id++;
    @(negedge CLOCK);
    START = 1'b1;
    wait_strobes(base + 8, ok);
    check("hold_reach8", int'(ok), 1);
    START = 1'b0;
    ref_run(12, 1, exp);
    finish_check("start_held", base, exp, NSTR, 1'b1);

    // reset during the first confirm wait
    base = strobes.size();
    start_run(9, 5, 1'b1);
    wait_strobes(base + 5, ok);
    check("rstmid_reach5", int'(ok), 1);
    @(negedge CLOCK);
    RESET_N = 1'b0;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    check("rstmid_tentativa", int'(TENTATIVA), 0);
    check("rstmid_enter", int'(ENTER), 0);
    check("rstmid_ocupado", int'(OCUPADO), 0);
    check("rstmid_pronto", int'(PRONTO), 0);
    check("rstmid_erro", int'(ERRO), 0);
    check("rstmid_num_tent", int'(NUM_TENT), 0);
    repeat (5) @(negedge CLOCK);
    ref_run(3, 2, exp);
    do_run("after_rst", 3, 2, 1'b1, exp, NSTR, 1'b1);

    // randomized secrets against the reference search
    for (int r = 0; r < 12; r++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << LA) - 1));
      b = int'($urandom_range(0, (1 << LB) - 1));
      ref_run(a, b, exp);
      do_run($sformatf("rnd%0d_a%0d_b%0d", r, a, b), a, b, 1'b1, exp, NSTR, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
